apb_gpio_ctrl: RTL and testbench
================================

Name: apb_gpio_ctrl

Overview:
- APB3 slave controller that sequences register accesses into the 8-bit GPIO block's BUSW/REGSEL/BUSWDATA/BUSRDATA interface.
- Decodes the address, issues single-cycle write strobes and waits out the GPIO read latency before completing the transfer.
- Keeps shadow copies of PCTL/DIR/PORT, because GPIO BUSRDATA returns only pin state.
- Sits between the APB interconnect and the GPIO instance. Exports UART-mode status for pin muxing.

Parameters:
- RD_LAT, 1, cycles BUSW held low before sampling gpio_rdata on a PIN read (legal range 1..7).
- ADDR_W, 8, APB address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB enable phase
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_W  byte address
- pwdata  in  8  write data
- prdata  out  8  read data, valid only while pready=1
- pready  out  1  transfer complete
- pslverr  out  1  error response, valid only while pready=1
- gpio_busw  out  1  GPIO BUSW strobe
- gpio_regsel  out  2  GPIO REGSEL
- gpio_wdata  out  8  GPIO BUSWDATA
- gpio_rdata  in  8  GPIO BUSRDATA (pin state)
- uart_mode  out  1  shadow PCTL[0]

Behaviour:
- Clock and reset: one clock domain, clk; reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values: state=IDLE; prdata=0x00; pready=0; pslverr=0; gpio_busw=0; gpio_regsel=2'b00; gpio_wdata=0x00. Shadows pctl_sh=0, dir_sh=0x00, port_sh=0x00; uart_mode=0.
- Reset asserted mid-transfer takes effect at the next edge and aborts the transfer: no pready, no further busw.
- Address map (by paddr[3:2]):
  - 0x0 PIN: read-only.
  - 0x4 PCTL: bit0 only; upper bits read 0.
  - 0x8 DIR.
  - 0xC PORT.
- Error cases (pslverr=1):
  - paddr[ADDR_W-1:4]!=0.
  - paddr[1:0]!=0.
  - Write to 0x0.
- On error: no GPIO strobe; prdata=0x00.
- FSM states: IDLE, WR, RD_WAIT, RESP.
  - IDLE: on psel=1 & penable=0 (setup, cycle N), latch paddr/pwrite/pwdata and decode.
    - Error -> RESP with pslverr.
    - Valid write -> WR.
    - PIN read -> RD_WAIT with counter=RD_LAT.
    - Shadow read -> RESP with prdata=shadow.
  - WR (cycle N+1): gpio_busw=1, gpio_regsel=addr[3:2], gpio_wdata=latched data, held exactly this one cycle. Shadows update at the end of this cycle. Next state RESP.
  - RD_WAIT: gpio_busw=0, gpio_regsel=2'b00. Counter decrements each cycle; at 1, capture gpio_rdata into prdata and go to RESP. PIN read pready appears at cycle N+RD_LAT+1.
  - RESP: pready=1 for exactly one cycle, with prdata/pslverr valid. Next state IDLE. pready, pslverr and prdata return to 0 the following cycle.
- Latencies (setup at cycle N):
  - Write: pready at cycle N+2.
  - Shadow read or error: pready at cycle N+1, zero wait.
- PCTL write side effect: writing 0x4 with pwdata[0]=1 also sets dir_sh=0x02, mirroring the GPIO forcing DIR for TX/RX. Writing pwdata[0]=0 leaves dir_sh unchanged.
- Abort: psel=0 in any non-IDLE state -> IDLE next edge, no pready.
  - If abort occurs in WR, the strobe already issued stands and the shadows update.
  - Back-to-back: a new setup is accepted only from IDLE. The cycle after RESP is IDLE, so the minimum spacing is one idle cycle.
- penable=1 while in IDLE is ignored: no transfer starts without a setup phase.
- gpio_busw is never high outside WR.

Test Plan:
- Reset then read 0x8 -> pready at N+1, prdata=0x00, pslverr=0, gpio_busw never high.
- Write 0xC=0xA5 -> gpio_busw=1 only at N+1 with regsel=2'b11, wdata=0xA5; pready at N+2; read 0xC returns 0xA5.
- Write 0x4=0x01 -> regsel=2'b01, uart_mode=1; read 0x8 returns 0x02; read 0x4 returns 0x01.
- gpio_rdata=0x3C, RD_LAT=1, read 0x0 -> busw=0 at N+1, pready at N+2, prdata=0x3C. With RD_LAT=3, pready at N+4.
- Write 0x0, read 0x10, read 0x6 -> each pready at N+1, pslverr=1, prdata=0x00, no busw pulse, shadows unchanged.
- rst_n=0 during RD_WAIT -> next edge all outputs zero, no pready. psel dropped during RD_WAIT -> IDLE, no pready, next transfer completes normally.

Source files
------------

// File: rtl/apb_gpio_ctrl_if.sv
// APB3 bus bundle between the interconnect (master) and the GPIO sequencer (slave).
// Read data is 8 bits wide because the GPIO register file is 8 bits wide.
interface apb_gpio_ctrl_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_gpio_ctrl.sv
// APB3 slave that sequences register accesses onto the 8-bit GPIO BUSW/REGSEL bus.
// It shadows PCTL/DIR/PORT, because the GPIO read path only returns pin state.
module apb_gpio_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  apb_gpio_ctrl_if.slave  apb,
  output logic            gpio_busw,
  output logic [1:0]      gpio_regsel,
  output logic [7:0]      gpio_wdata,
  input  logic [7:0]      gpio_rdata,
  output logic            uart_mode
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] REG_PIN  = 2'b00;
  localparam logic [1:0] REG_PCTL = 2'b01;
  localparam logic [1:0] REG_DIR  = 2'b10;
  localparam logic [1:0] REG_PORT = 2'b11;

  // PCTL TX/RX enable forces these pins to outputs inside the GPIO block.
  localparam logic [DATA_W-1:0] DIR_UART = 8'h02;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WR      = 2'b01,
    RD_WAIT = 2'b10,
    RESP    = 2'b11
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]        sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              pctl_sh;
  logic [DATA_W-1:0] dir_sh;
  logic [DATA_W-1:0] port_sh;

  logic              setup;
  logic              addr_err;
  logic              dec_err;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] shadow_rd;

  logic              pready_d;
  logic              pslverr_d;
  logic [DATA_W-1:0] prdata_d;
  logic              busw_d;
  logic [1:0]        regsel_d;
  logic [DATA_W-1:0] wdata_d;

  assign setup    = apb.psel & ~apb.penable;
  assign reg_sel  = apb.paddr[3:2];
  assign addr_err = (apb.paddr[ADDR_W-1:4] != '0) || (apb.paddr[1:0] != 2'b00);
  assign dec_err  = addr_err || (apb.pwrite && (reg_sel == REG_PIN));

  // Shadow read mux; PIN never reaches this path.
  always_comb begin
    shadow_rd = '0;
    case (reg_sel)
      REG_PCTL: shadow_rd = {(DATA_W-1)'(0), pctl_sh};
      REG_DIR:  shadow_rd = dir_sh;
      REG_PORT: shadow_rd = port_sh;
      default:  shadow_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; dropping psel outside IDLE abandons the transfer silently.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (setup) begin
          if (dec_err) begin
            state_nx = RESP;
          end else if (apb.pwrite) begin
            state_nx = WR;
          end else if (reg_sel == REG_PIN) begin
            state_nx = RD_WAIT;
          end else begin
            state_nx = RESP;
          end
        end
      end
      WR: begin
        state_nx = apb.psel ? RESP : IDLE;
      end
      RD_WAIT: begin
        if (!apb.psel) begin
          state_nx = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output values for the next cycle; every bus output is a flop.
  always_comb begin
    pready_d  = (state_nx == RESP);
    pslverr_d = 1'b0;
    prdata_d  = '0;
    busw_d    = 1'b0;
    regsel_d  = 2'b00;
    wdata_d   = '0;
    case (state)
      IDLE: begin
        if (setup) begin
          if (dec_err) begin
            pslverr_d = 1'b1;
          end else if (apb.pwrite) begin
            busw_d   = 1'b1;
            regsel_d = reg_sel;
            wdata_d  = apb.pwdata;
          end else if (reg_sel != REG_PIN) begin
            prdata_d = shadow_rd;
          end
        end
      end
      RD_WAIT: begin
        if (state_nx == RESP) begin
          prdata_d = gpio_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
      gpio_busw   <= 1'b0;
      gpio_regsel <= 2'b00;
      gpio_wdata  <= '0;
    end else begin
      apb.pready  <= pready_d;
      apb.pslverr <= pslverr_d;
      apb.prdata  <= prdata_d;
      gpio_busw   <= busw_d;
      gpio_regsel <= regsel_d;
      gpio_wdata  <= wdata_d;
    end
  end

  // Setup-phase capture and read-latency countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q   <= 2'b00;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if ((state == IDLE) && setup) begin
        sel_q   <= reg_sel;
        wdata_q <= apb.pwdata;
        cnt_q   <= CNT_W'(RD_LAT);
      end else if (state == RD_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Shadows commit at the end of the strobe cycle, even if the master aborts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pctl_sh <= 1'b0;
      dir_sh  <= '0;
      port_sh <= '0;
    end else if (state == WR) begin
      case (sel_q)
        REG_PCTL: begin
          pctl_sh <= wdata_q[0];
          if (wdata_q[0]) begin
            dir_sh <= DIR_UART;
          end
        end
        REG_DIR:  dir_sh  <= wdata_q;
        REG_PORT: port_sh <= wdata_q;
        default: begin
        end
      endcase
    end
  end

  assign uart_mode = pctl_sh;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Scoreboard bench for apb_gpio_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share
// one APB driver; psel is steered to one of them and their outputs are OR-merged.
module tb_apb_gpio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel, penable, pwrite, tgt;
  logic [7:0] paddr, pwdata, gpio_rdata;

  logic       busw1, busw3, uart1, uart3;
  logic [1:0] regsel1, regsel3;
  logic [7:0] wdata1, wdata3;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] rdata;
    logic       err;
    int         setup;
    int         lat;
  } rsp_t;

  typedef struct {
    logic [1:0] regsel;
    logic [7:0] wdata;
    int         at;
  } stb_t;

  rsp_t rsp_q[$];
  stb_t stb_q[$];
  rsp_t mon_r;
  stb_t mon_s;

  apb_gpio_ctrl_if #(.ADDR_W(8)) if1 ();
  apb_gpio_ctrl_if #(.ADDR_W(8)) if3 ();

  assign if1.psel    = psel & ~tgt;
  assign if3.psel    = psel & tgt;
  assign if1.penable = penable;
  assign if3.penable = penable;
  assign if1.pwrite  = pwrite;
  assign if3.pwrite  = pwrite;
  assign if1.paddr   = paddr;
  assign if3.paddr   = paddr;
  assign if1.pwdata  = pwdata;
  assign if3.pwdata  = pwdata;

  apb_gpio_ctrl #(.RD_LAT(1), .ADDR_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .apb(if1),
    .gpio_busw(busw1), .gpio_regsel(regsel1), .gpio_wdata(wdata1),
    .gpio_rdata(gpio_rdata), .uart_mode(uart1)
  );

  apb_gpio_ctrl #(.RD_LAT(3), .ADDR_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .apb(if3),
    .gpio_busw(busw3), .gpio_regsel(regsel3), .gpio_wdata(wdata3),
    .gpio_rdata(gpio_rdata), .uart_mode(uart3)
  );

  // An idle instance drives all zeros, so OR-merging exposes stray activity.
  wire       pready_m  = if1.pready | if3.pready;
  wire       pslverr_m = if1.pslverr | if3.pslverr;
  wire [7:0] prdata_m  = if1.prdata | if3.prdata;
  wire       busw_m    = busw1 | busw3;
  wire [1:0] regsel_m  = regsel1 | regsel3;
  wire [7:0] wdata_m   = wdata1 | wdata3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Full APB transfer; expectations are queued at setup time.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input logic exp_err, input int exp_lat);
    rsp_t r;
    stb_t s;
    int   n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    r.addr = addr; r.rdata = exp_rd; r.err = exp_err; r.setup = cyc; r.lat = exp_lat;
    rsp_q.push_back(r);
    if (wr && !exp_err) begin
      s.regsel = addr[3:2]; s.wdata = wd; s.at = cyc + 1;
      stb_q.push_back(s);
    end
    @(posedge clk); #1 penable = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (pready_m) break;
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL timeout addr=0x%02h: no pready within 20 cycles", addr);
        break;
      end
    end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  // Monitor: every pready and every strobe must match a queued expectation.
  always @(negedge clk) begin
    if (pready_m) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready at cycle %0d: prdata=0x%02h pslverr=%0b",
                 cyc, prdata_m, pslverr_m);
      end else begin
        mon_r = rsp_q.pop_front();
        if (prdata_m !== mon_r.rdata || pslverr_m !== mon_r.err || (cyc - mon_r.setup) != mon_r.lat) begin
          errors++;
          $display("FAIL resp addr=0x%02h: got prdata=0x%02h err=%0b lat=%0d, expected prdata=0x%02h err=%0b lat=%0d",
                   mon_r.addr, prdata_m, pslverr_m, cyc - mon_r.setup, mon_r.rdata, mon_r.err, mon_r.lat);
        end
      end
    end
    if (busw_m) begin
      checks++;
      if (stb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_busw at cycle %0d: regsel=%0d wdata=0x%02h", cyc, regsel_m, wdata_m);
      end else begin
        mon_s = stb_q.pop_front();
        if (regsel_m !== mon_s.regsel || wdata_m !== mon_s.wdata || cyc != mon_s.at) begin
          errors++;
          $display("FAIL strobe: got regsel=%0d wdata=0x%02h cycle=%0d, expected regsel=%0d wdata=0x%02h cycle=%0d",
                   regsel_m, wdata_m, cyc, mon_s.regsel, mon_s.wdata, mon_s.at);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tgt = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; gpio_rdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {pready_m, pslverr_m, busw_m, regsel_m, uart1, uart3, 1'b0}, 8'h00);
    check("reset_prdata", prdata_m, 8'h00);
    check("reset_wdata", wdata_m, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;

    // RD_LAT=1 instance: shadows, writes, PIN read, errors
    xfer(1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1);
    xfer(1'b1, 8'h0C, 8'hA5, 8'h00, 1'b0, 2);
    xfer(1'b0, 8'h0C, 8'h00, 8'hA5, 1'b0, 1);
    xfer(1'b1, 8'h04, 8'h01, 8'h00, 1'b0, 2);
    check("uart_mode_set", {7'd0, uart1}, 8'h01);
    xfer(1'b0, 8'h08, 8'h00, 8'h02, 1'b0, 1);
    xfer(1'b0, 8'h04, 8'h00, 8'h01, 1'b0, 1);
    gpio_rdata = 8'h3C;
    xfer(1'b0, 8'h00, 8'h00, 8'h3C, 1'b0, 2);
    xfer(1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 1);
    xfer(1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 1);
    xfer(1'b0, 8'h06, 8'h00, 8'h00, 1'b1, 1);
    xfer(1'b1, 8'h0D, 8'h77, 8'h00, 1'b1, 1);
    xfer(1'b0, 8'h0C, 8'h00, 8'hA5, 1'b0, 1);
    xfer(1'b0, 8'h08, 8'h00, 8'h02, 1'b0, 1);
    xfer(1'b1, 8'h08, 8'h5A, 8'h00, 1'b0, 2);
    xfer(1'b1, 8'h04, 8'h00, 8'h00, 1'b0, 2);
    check("uart_mode_clr", {7'd0, uart1}, 8'h00);
    xfer(1'b0, 8'h08, 8'h00, 8'h5A, 1'b0, 1);
    xfer(1'b1, 8'h04, 8'hFE, 8'h00, 1'b0, 2);
    xfer(1'b0, 8'h04, 8'h00, 8'h00, 1'b0, 1);

    // penable without a setup phase must not start anything
    @(posedge clk); #1 psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h08;
    repeat (3) @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;

    // RD_LAT=3 instance
    tgt = 1'b1;
    gpio_rdata = 8'hC3;
    xfer(1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 4);
    xfer(1'b1, 8'h0C, 8'h11, 8'h00, 1'b0, 2);
    xfer(1'b0, 8'h0C, 8'h00, 8'h11, 1'b0, 1);

    // psel dropped during RD_WAIT: no response, next transfer is clean
    @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    repeat (6) @(posedge clk);
    xfer(1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 4);

    // reset asserted during RD_WAIT aborts and clears everything
    @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ctrl", {pready_m, pslverr_m, busw_m, regsel_m, uart1, uart3, 1'b0}, 8'h00);
    check("midrst_prdata", prdata_m, 8'h00);
    #1 psel = 1'b0; penable = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    xfer(1'b0, 8'h0C, 8'h00, 8'h00, 1'b0, 1);
    tgt = 1'b0;
    xfer(1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rsp_q_drained", 8'(rsp_q.size()), 8'h00);
    check("stb_q_drained", 8'(stb_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
